piso_shift_tx: RTL
==================

# piso_shift_tx

Parallel-in, serial-out shift transmitter: the serializing end of the team's shift-register datapath. It captures a WIDTH-bit parallel word under a valid/ready handshake and shifts it out one bit per clock. Each bit carries a valid flag and last-bit framing, so a downstream serial-in/parallel-out receiver can rebuild the word. It runs back-to-back with no idle gap when the next word is offered on the last bit.

## Interface
- WIDTH, 4: parallel word width; legal range 2..32.
- MSB_FIRST, 1: 1 sends pin[WIDTH-1] first; 0 sends pin[0] first.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pin  in  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load  in  1  word-valid strobe from the producer.
- ready  out  1  transmitter can accept a word this cycle.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout carries a frame bit this cycle.
- sout_last  out  1  the current sout bit is the final bit of its word.
- busy  out  1  a frame is in progress (state SHIFT).

## Operation
- State machine: IDLE, SHIFT.
- Internal registers: shift register sreg[WIDTH], bit counter cnt of $clog2(WIDTH) bits.
- Accept rule: a word is accepted on a clock edge where load=1 and ready=1.
- Output decode:
  - ready = (state==IDLE) | (state==SHIFT & cnt==0). This is combinational from registered state, with no path from load.
  - busy = (state==SHIFT).
  - sout_valid = busy.
  - sout_last = busy & (cnt==0).
- IDLE:
  - sout=0, sout_valid=0.
  - On accept: sreg<=pin, cnt<=WIDTH-1, go to SHIFT.
- SHIFT:
  - sout = sreg[WIDTH-1] when MSB_FIRST=1, sreg[0] otherwise.
  - Each edge, sreg shifts toward the output end with 0 fill, and cnt decrements.
- End of word, at the edge where cnt==0:
  - If a word is accepted, reload sreg and cnt and stay in SHIFT (back-to-back).
  - Otherwise go to IDLE.
- A load while ready=0 is ignored: no capture, no error flag. The producer must hold load until it sees ready.
- pin is don't-care except on the accept edge.

## Timing
- Reset asserted (asynchronous, immediate): state=IDLE, sreg=0, cnt=0. Outputs are sout=0, sout_valid=0, sout_last=0, busy=0, ready=1.
- load is ignored while reset is asserted.
- Reset mid-frame aborts the frame; the outputs above apply within the same cycle with no clock needed.
- Release is synchronous in effect: the first accept can occur on the first rising edge after reset goes to 1.
- Latency: accept at edge N → first bit on sout during cycle N+1 → last bit during cycle N+WIDTH, with sout_last=1.
- Throughput: one word per WIDTH cycles with sustained load; zero-gap frames.
- Simultaneous events:
  - Accept on a last-bit edge: the old word's last bit completes and the new first bit follows in the next cycle.
  - Reset combined with load: reset wins.

## Structure
- Shared package piso_pkg holds:
  - typedef enum {IDLE, SHIFT} piso_state_t;
  - constant PISO_DEF_WIDTH = 4.
  - Reused by the matching SIPO receiver and the bench.
- One sub-module is natural: piso_shift_core.
  - Loadable shift register plus down-counter.
  - Ports: clk, reset, ld, en, d[WIDTH], q_bit, cnt_zero.
  - The top level holds only the FSM and handshake decode.

## Test plan
All scenarios use WIDTH=4 and MSB_FIRST=1 unless stated.
- Reset: hold reset=0 with pin=0000 and load=1 for 2 cycles → sout=0, sout_valid=0, sout_last=0, busy=0, ready=1; no capture occurs.
- Single word: accept pin=0101 → sout=0,1,0,1 in 4 consecutive cycles with sout_valid=1 and sout_last=1 only on the 4th. Then IDLE, sout_valid=0, ready=1.
- Back-to-back: accept 0110, then hold load=1 with pin=1101 → accepted on the last-bit edge, giving 8 contiguous valid bits 0,1,1,0,1,1,0,1 with sout_last on bits 4 and 8.
- Ignored load: accept 0111, then pulse load with pin=1111 during bit 2 → serial output remains 0,1,1,1 and 1111 is never transmitted.
- Mid-frame reset: accept 0111, assert reset after 2 bits → all outputs go to 0 asynchronously and ready=1. After release, accepting 0100 transmits 0,1,0,0 cleanly.
- LSB-first: MSB_FIRST=0, accept 0001 → sout=1,0,0,0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO transmitter and its matching SIPO receiver.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_DEF_WIDTH = 4;

  // Counter width for a WIDTH-bit frame; never below 1 bit.
  function automatic int piso_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Loadable shift register plus bit down-counter for the PISO transmitter.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit,
  output logic             cnt_zero
);

  localparam int CW = piso_cnt_w(WIDTH);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (ld) begin
      sreg_d = d;
      cnt_d  = CW'(WIDTH - 1);
    end else if (en) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
      // Hold at zero so an idle transmitter keeps cnt==0.
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_bit    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// PISO transmitter: valid/ready word capture, one framed bit per clock, zero-gap reload.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  piso_state_t state_q;
  logic        q_bit;
  logic        cnt_zero;
  logic        accept;

  // ready depends only on registered state, never on load.
  assign busy       = (state_q == SHIFT);
  assign ready      = (state_q == IDLE) | (busy & cnt_zero);
  assign accept     = load & ready;
  assign sout_valid = busy;
  assign sout_last  = busy & cnt_zero;
  assign sout       = busy & q_bit;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .ld       (accept),
    .en       (busy),
    .d        (pin),
    .q_bit    (q_bit),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= SHIFT;
        SHIFT:   if (cnt_zero && !accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
